// File: rtl/sevseg_pkg.sv
// Shared constants, types and the digit-select helper for the seven-segment scan driver.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_t;

  localparam digit_t D_MIN_ONES = 2'd0;
  localparam digit_t D_MIN_TENS = 2'd1;
  localparam digit_t D_HR_ONES  = 2'd2;
  localparam digit_t D_HR_TENS  = 2'd3;

  // Field positions inside a 14-bit {tens, ones} encoded pair.
  localparam int unsigned TENS_HI = 13;
  localparam int unsigned TENS_LO = 7;
  localparam int unsigned ONES_HI = 6;
  localparam int unsigned ONES_LO = 0;

  typedef struct packed {
    logic [13:0] hr_seg;
    logic [13:0] min_seg;
    logic [3:0]  dp_mask;
    logic        blink_en;
    logic [1:0]  blink_sel;
  } shadow_t;

  localparam shadow_t SHADOW_RESET = '{
    hr_seg:    {SEG_BLANK, SEG_BLANK},
    min_seg:   {SEG_BLANK, SEG_BLANK},
    dp_mask:   4'h0,
    blink_en:  1'b0,
    blink_sel: 2'b00
  };

  function automatic logic [6:0] digit_code(input logic [13:0] hr, input logic [13:0] mn,
                                            input digit_t d);
    logic [6:0] code;
    code = SEG_BLANK;
    unique case (d)
      D_MIN_ONES: code = mn[ONES_HI:ONES_LO];
      D_MIN_TENS: code = mn[TENS_HI:TENS_LO];
      D_HR_ONES:  code = hr[ONES_HI:ONES_LO];
      D_HR_TENS:  code = hr[TENS_HI:TENS_LO];
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sevseg_tick_div.sv
// Free-running modulo-N counter with a one-cycle wrap strobe on its last count.
module sevseg_tick_div #(
  parameter int unsigned N = 10,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cnt_d, cnt_q;

  assign wrap_o = (cnt_q == Last);
  assign cnt_d  = wrap_o ? '0 : cnt_q + W'(1);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking, frame-coherent input
// snapshot and pair blinking. All outputs are registered (one cycle behind the scan state).
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_HZ     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] hr_seg,
  input  logic [13:0] min_seg,
  input  logic [3:0]  dp_mask,
  input  logic        blink_en,
  input  logic [1:0]  blink_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned DIV    = CLK_HZ / REFRESH_HZ;
  localparam int unsigned HP     = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SlotW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BlinkW = (HP > 1) ? $clog2(HP) : 1;

  localparam logic [SlotW-1:0] BlankEnd = SlotW'(BLANK_CYCLES);

  logic [SlotW-1:0]  slot_cnt;
  logic              slot_wrap;
  logic [BlinkW-1:0] unused_blink_cnt;
  logic              blink_wrap;

  digit_t  digit_d, digit_q;
  logic    blink_phase_d, blink_phase_q;
  shadow_t shadow_d, shadow_q;
  logic    snap;
  logic    blanked;

  logic [3:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;
  logic       dp_d, dp_q;
  logic       frame_tick_d, frame_tick_q;

  sevseg_tick_div #(
    .N(DIV),
    .W(SlotW)
  ) u_slot_div (
    .clk_i  (clk),
    .reset_i(reset),
    .cnt_o  (slot_cnt),
    .wrap_o (slot_wrap)
  );

  // Only the wrap strobe of the blink timer matters; its count is deliberately dropped.
  sevseg_tick_div #(
    .N(HP),
    .W(BlinkW)
  ) u_blink_div (
    .clk_i  (clk),
    .reset_i(reset),
    .cnt_o  (unused_blink_cnt),
    .wrap_o (blink_wrap)
  );

  assign snap = (digit_q == D_MIN_ONES) && (slot_cnt == '0);

  // Digits 2/3 belong to the hours pair (blink_sel[1]), digits 0/1 to minutes (blink_sel[0]).
  assign blanked = shadow_q.blink_en & blink_phase_q &
                   (digit_q[1] ? shadow_q.blink_sel[1] : shadow_q.blink_sel[0]);

  always_comb begin
    digit_d       = digit_q;
    blink_phase_d = blink_phase_q;
    shadow_d      = shadow_q;
    if (slot_wrap) begin
      digit_d = digit_q + 2'd1;
    end
    if (blink_wrap) begin
      blink_phase_d = ~blink_phase_q;
    end
    if (snap) begin
      shadow_d = '{
        hr_seg:    hr_seg,
        min_seg:   min_seg,
        dp_mask:   dp_mask,
        blink_en:  blink_en,
        blink_sel: blink_sel
      };
    end
  end

  always_comb begin
    an_d         = 4'hF;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    frame_tick_d = snap;
    if (slot_cnt >= BlankEnd) begin
      an_d = ~(4'b0001 << digit_q);
      if (!blanked) begin
        seg_d = digit_code(shadow_q.hr_seg, shadow_q.min_seg, digit_q);
        dp_d  = ~shadow_q.dp_mask[digit_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q       <= D_MIN_ONES;
      blink_phase_q <= 1'b0;
      shadow_q      <= SHADOW_RESET;
      an_q          <= 4'hF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      digit_q       <= digit_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver: DIV=10, BLANK_CYCLES=2, blink half-period 20.
module tb_sevseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] hr_seg;
  logic [13:0] min_seg;
  logic [3:0]  dp_mask;
  logic        blink_en;
  logic [1:0]  blink_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  sevseg_scan_driver #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2),
    .BLINK_HZ    (25)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hr_seg    (hr_seg),
    .min_seg   (min_seg),
    .dp_mask   (dp_mask),
    .blink_en  (blink_en),
    .blink_sel (blink_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          k = 0;  // cycles since reset release; output after edge k reflects scan state k

  // Inputs as captured at the most recent frame start.
  logic [13:0] f_hr, f_min;
  logic [3:0]  f_dp;
  logic        f_ben;
  logic [1:0]  f_bsel;

  // Hand-computed first display cycle of each digit for "24:00".
  logic [3:0] spot_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] spot_seg [4] = '{7'h01, 7'h01, 7'h4C, 7'h12};
  bit         spot_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic step_model();
    logic [1:0] d;
    int         s;
    logic       ph;
    logic       blk;
    logic [6:0] c;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (k % 40 == 0) begin
      f_hr   = hr_seg;
      f_min  = min_seg;
      f_dp   = dp_mask;
      f_ben  = blink_en;
      f_bsel = blink_sel;
    end
    @(posedge clk);
    @(negedge clk);
    s  = k % 10;
    d  = 2'((k / 10) % 4);
    ph = ((k / 20) % 2) == 1;
    case (d)
      2'd0:    c = f_min[6:0];
      2'd1:    c = f_min[13:7];
      2'd2:    c = f_hr[6:0];
      default: c = f_hr[13:7];
    endcase
    blk = f_ben && ph && ((d >= 2'd2) ? f_bsel[1] : f_bsel[0]);
    if (s < 2) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << d);
      e_seg = blk ? 7'h7F : c;
      e_dp  = blk ? 1'b1 : ~f_dp[d];
    end
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame_tick", 32'(frame_tick), 32'(k % 40 == 0));
    if (spot_en && s == 2) begin
      check_eq("spot_an", 32'(an), 32'(spot_an[d]));
      check_eq("spot_seg", 32'(seg), 32'(spot_seg[d]));
    end
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step_model();
  endtask

  initial begin
    hr_seg    = 14'b0010010_1001100;  // "24"
    min_seg   = 14'b0000001_0000001;  // "00"
    dp_mask   = 4'b0000;
    blink_en  = 1'b0;
    blink_sel = 2'b00;

    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    reset = 1'b0;

    // Mid-frame input changes must not tear the current frame.
    run_to(15);
    hr_seg = 14'b1001111_0000110;     // "13"
    run_to(25);
    min_seg = 14'b0100100_0000100;    // "59"
    run_to(35);
    dp_mask = 4'b0100;
    run_to(40);
    spot_en = 1'b0;

    run_to(75);
    blink_en  = 1'b1;
    blink_sel = 2'b10;
    run_to(155);
    blink_sel = 2'b11;
    run_to(195);
    blink_en = 1'b0;

    // Reset while digit 3 is on display.
    run_to(236);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_mid");
    end
    hr_seg    = 14'b0010010_1001100;
    min_seg   = 14'b0000001_0000001;
    dp_mask   = 4'b0001;
    blink_sel = 2'b00;
    reset     = 1'b0;
    k         = 0;
    spot_en   = 1'b0;
    run_to(45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
